// File: rtl/if_stage.sv
// Instruction fetch stage: pairs fetch addresses with in-order SRAM returns,
// buffers stalled words, and discards returns orphaned by writeback flushes.
module if_stage #(
  parameter logic [4:0] EXC_ADEL = 5'h04
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pfs_to_fs_valid,
  input  logic [64:0] pfs_to_fs_bus,
  input  logic        pfs_inst_waiting,
  output logic        fs_allowin,
  output logic        fs_valid,
  output logic        fs_inst_unable,
  input  logic [31:0] inst_sram_rdata,
  input  logic        inst_sram_data_ok,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [69:0] fs_to_ds_bus,
  input  logic        ws_ex,
  input  logic        ws_eret
);

  logic        buf_full;
  logic [31:0] buf_inst;
  logic [31:0] fs_pc;
  logic [1:0]  cancel_cnt;

  logic        cnt_zero;
  logic        waiting;
  logic        claim;
  logic        fs_ready_go;
  logic        flush;
  logic        accept;
  logic        adel;
  logic [31:0] inst_out;
  logic [1:0]  cnt_inc;
  logic        cnt_dec;
  logic [2:0]  cnt_sum;

  assign cnt_zero    = (cancel_cnt == 2'd0);
  assign waiting     = fs_valid && !buf_full;
  assign claim       = waiting && inst_sram_data_ok && cnt_zero;
  assign fs_ready_go = buf_full || claim;
  assign flush       = ws_ex || ws_eret;
  assign fs_allowin  = !fs_valid || (fs_ready_go && ds_allowin);
  assign accept      = pfs_to_fs_valid && fs_allowin;

  assign fs_to_ds_valid = fs_valid && fs_ready_go && !flush;
  assign fs_inst_unable = !waiting && cnt_zero;

  assign adel     = (fs_pc[1:0] != 2'b00);
  assign inst_out = adel     ? 32'h0
                  : buf_full ? buf_inst
                  :            inst_sram_rdata;

  assign fs_to_ds_bus = {adel,
                         adel ? EXC_ADEL : 5'h00,
                         inst_out,
                         fs_pc};

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      buf_full <= 1'b0;
      buf_inst <= 32'h0;
      fs_pc    <= 32'h0;
    end else if (accept) begin
      fs_valid <= 1'b1;
      fs_pc    <= pfs_to_fs_bus[31:0];
      buf_full <= pfs_to_fs_bus[64];
      buf_inst <= pfs_to_fs_bus[63:32];
    end else if (flush || fs_allowin) begin
      fs_valid <= 1'b0;
      buf_full <= 1'b0;
    end else if (claim) begin
      // decode is stalled: park the word until handoff
      buf_full <= 1'b1;
      buf_inst <= inst_sram_rdata;
    end
  end

  // returns still in flight at flush time belong to dead fetches
  always_comb begin
    cnt_inc = 2'd0;
    if (flush) begin
      cnt_inc = {1'b0, waiting && !(inst_sram_data_ok && cnt_zero)}
              + {1'b0, pfs_inst_waiting};
    end
    cnt_dec = inst_sram_data_ok && !cnt_zero;
    cnt_sum = {1'b0, cancel_cnt} + {1'b0, cnt_inc} - {2'b00, cnt_dec};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cancel_cnt <= 2'd0;
    end else if (cnt_sum > 3'd2) begin
      cancel_cnt <= 2'd2;
    end else begin
      cancel_cnt <= cnt_sum[1:0];
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: handoff, buffering, flush cancel,
// misaligned fetch and mid-flight reset.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        pfs_to_fs_valid;
  logic [64:0] pfs_to_fs_bus;
  logic        pfs_inst_waiting;
  logic        fs_allowin;
  logic        fs_valid;
  logic        fs_inst_unable;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_data_ok;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [69:0] fs_to_ds_bus;
  logic        ws_ex;
  logic        ws_eret;

  int checks = 0;
  int failures = 0;

  if_stage #(.EXC_ADEL(5'h04)) dut (
    .clk              (clk),
    .reset            (reset),
    .pfs_to_fs_valid  (pfs_to_fs_valid),
    .pfs_to_fs_bus    (pfs_to_fs_bus),
    .pfs_inst_waiting (pfs_inst_waiting),
    .fs_allowin       (fs_allowin),
    .fs_valid         (fs_valid),
    .fs_inst_unable   (fs_inst_unable),
    .inst_sram_rdata  (inst_sram_rdata),
    .inst_sram_data_ok(inst_sram_data_ok),
    .ds_allowin       (ds_allowin),
    .fs_to_ds_valid   (fs_to_ds_valid),
    .fs_to_ds_bus     (fs_to_ds_bus),
    .ws_ex            (ws_ex),
    .ws_eret          (ws_eret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pfs_to_fs_valid   = 1'b0;
    pfs_to_fs_bus     = '0;
    pfs_inst_waiting  = 1'b0;
    inst_sram_rdata   = 32'h0;
    inst_sram_data_ok = 1'b0;
    ds_allowin        = 1'b1;
    ws_ex             = 1'b0;
    ws_eret           = 1'b0;
  endtask

  task automatic fetch(input logic ok, input logic [31:0] inst,
                       input logic [31:0] pc);
    pfs_to_fs_valid = 1'b1;
    pfs_to_fs_bus   = {ok, inst, pc};
    step();
    pfs_to_fs_valid = 1'b0;
    pfs_to_fs_bus   = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++; if (fs_allowin !== 1'b1) begin failures++; $display("FAIL rst_allowin got=%0h exp=1", fs_allowin); end
    checks++; if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL rst_ds_valid got=%0h exp=0", fs_to_ds_valid); end
    checks++; if (fs_inst_unable !== 1'b1) begin failures++; $display("FAIL rst_unable got=%0h exp=1", fs_inst_unable); end
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL rst_fs_valid got=%0h exp=0", fs_valid); end
  endtask

  task automatic test_bypass();
    idle();
    fetch(1'b0, 32'h0, 32'hbfc00000);
    #1;
    checks++; if (fs_inst_unable !== 1'b0) begin failures++; $display("FAIL byp_unable got=%0h exp=0", fs_inst_unable); end
    checks++; if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL byp_early got=%0h exp=0", fs_to_ds_valid); end
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h24020001;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1) begin failures++; $display("FAIL byp_valid got=%0h exp=1", fs_to_ds_valid); end
    checks++; if (fs_to_ds_bus !== {1'b0, 5'h00, 32'h24020001, 32'hbfc00000}) begin failures++; $display("FAIL byp_bus got=%h exp=%h", fs_to_ds_bus, {1'b0, 5'h00, 32'h24020001, 32'hbfc00000}); end
    checks++; if (fs_allowin !== 1'b1) begin failures++; $display("FAIL byp_allowin got=%0h exp=1", fs_allowin); end
    step();
    inst_sram_data_ok = 1'b0;
    #1;
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL byp_drain got=%0h exp=0", fs_valid); end
  endtask

  task automatic test_buffer();
    idle();
    fetch(1'b0, 32'h0, 32'hbfc00004);
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h24020001;
    ds_allowin        = 1'b0;
    #1;
    checks++; if (fs_allowin !== 1'b0) begin failures++; $display("FAIL buf_allowin0 got=%0h exp=0", fs_allowin); end
    step();
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'hdeadbeef;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (fs_allowin !== 1'b0) begin failures++; $display("FAIL buf_hold_allowin got=%0h exp=0", fs_allowin); end
      checks++; if (fs_to_ds_bus[63:32] !== 32'h24020001) begin failures++; $display("FAIL buf_hold_inst got=%h exp=24020001", fs_to_ds_bus[63:32]); end
      checks++; if (fs_inst_unable !== 1'b1) begin failures++; $display("FAIL buf_unable got=%0h exp=1", fs_inst_unable); end
      step();
    end
    ds_allowin = 1'b1;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1) begin failures++; $display("FAIL buf_hand_valid got=%0h exp=1", fs_to_ds_valid); end
    checks++; if (fs_to_ds_bus !== {1'b0, 5'h00, 32'h24020001, 32'hbfc00004}) begin failures++; $display("FAIL buf_hand_bus got=%h exp=%h", fs_to_ds_bus, {1'b0, 5'h00, 32'h24020001, 32'hbfc00004}); end
    checks++; if (fs_allowin !== 1'b1) begin failures++; $display("FAIL buf_hand_allowin got=%0h exp=1", fs_allowin); end
    step();
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL buf_drain got=%0h exp=0", fs_valid); end
  endtask

  task automatic test_cancel();
    idle();
    fetch(1'b0, 32'h0, 32'hbfc00008);
    ws_ex            = 1'b1;
    pfs_inst_waiting = 1'b1;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL can_ds_valid got=%0h exp=0", fs_to_ds_valid); end
    step();
    ws_ex            = 1'b0;
    pfs_inst_waiting = 1'b0;
    #1;
    checks++; if (dut.cancel_cnt !== 2'd2) begin failures++; $display("FAIL can_cnt2 got=%0d exp=2", dut.cancel_cnt); end
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL can_fs_valid got=%0h exp=0", fs_valid); end
    checks++; if (fs_inst_unable !== 1'b0) begin failures++; $display("FAIL can_unable2 got=%0h exp=0", fs_inst_unable); end
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h11111111;
    step();
    checks++; if (dut.cancel_cnt !== 2'd1) begin failures++; $display("FAIL can_cnt1 got=%0d exp=1", dut.cancel_cnt); end
    checks++; if (fs_inst_unable !== 1'b0) begin failures++; $display("FAIL can_unable1 got=%0h exp=0", fs_inst_unable); end
    checks++; if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL can_discard got=%0h exp=0", fs_to_ds_valid); end
    step();
    inst_sram_data_ok = 1'b0;
    #1;
    checks++; if (dut.cancel_cnt !== 2'd0) begin failures++; $display("FAIL can_cnt0 got=%0d exp=0", dut.cancel_cnt); end
    checks++; if (fs_inst_unable !== 1'b1) begin failures++; $display("FAIL can_unable0 got=%0h exp=1", fs_inst_unable); end
  endtask

  task automatic test_flush_claim();
    idle();
    fetch(1'b0, 32'h0, 32'hbfc0000c);
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h24020001;
    ws_eret           = 1'b1;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL fcl_ds_valid got=%0h exp=0", fs_to_ds_valid); end
    step();
    idle();
    #1;
    checks++; if (dut.cancel_cnt !== 2'd0) begin failures++; $display("FAIL fcl_cnt got=%0d exp=0", dut.cancel_cnt); end
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL fcl_fs_valid got=%0h exp=0", fs_valid); end
  endtask

  task automatic test_misaligned();
    idle();
    fetch(1'b0, 32'h0, 32'hbfc00002);
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'h12345678;
    #1;
    checks++; if (fs_to_ds_valid !== 1'b1) begin failures++; $display("FAIL adel_valid got=%0h exp=1", fs_to_ds_valid); end
    checks++; if (fs_to_ds_bus !== {1'b1, 5'h04, 32'h0, 32'hbfc00002}) begin failures++; $display("FAIL adel_bus got=%h exp=%h", fs_to_ds_bus, {1'b1, 5'h04, 32'h0, 32'hbfc00002}); end
    step();
    idle();
    fetch(1'b1, 32'h3c1d0001, 32'hbfc00010);
    #1;
    checks++; if (fs_to_ds_bus !== {1'b0, 5'h00, 32'h3c1d0001, 32'hbfc00010}) begin failures++; $display("FAIL instok_bus got=%h exp=%h", fs_to_ds_bus, {1'b0, 5'h00, 32'h3c1d0001, 32'hbfc00010}); end
    checks++; if (fs_to_ds_valid !== 1'b1) begin failures++; $display("FAIL instok_valid got=%0h exp=1", fs_to_ds_valid); end
    step();
  endtask

  task automatic test_reset_mid();
    idle();
    fetch(1'b0, 32'h0, 32'hbfc00014);
    ws_ex = 1'b1;
    step();
    ws_ex      = 1'b0;
    ds_allowin = 1'b0;
    fetch(1'b1, 32'h00000021, 32'hbfc00018);
    #1;
    checks++; if (dut.cancel_cnt !== 2'd1) begin failures++; $display("FAIL rmid_cnt got=%0d exp=1", dut.cancel_cnt); end
    checks++; if (fs_allowin !== 1'b0) begin failures++; $display("FAIL rmid_full got=%0h exp=0", fs_allowin); end
    reset             = 1'b1;
    inst_sram_data_ok = 1'b1;
    step();
    reset             = 1'b0;
    inst_sram_data_ok = 1'b0;
    ds_allowin        = 1'b1;
    #1;
    checks++; if (dut.cancel_cnt !== 2'd0) begin failures++; $display("FAIL rmid_cnt0 got=%0d exp=0", dut.cancel_cnt); end
    checks++; if (fs_valid !== 1'b0) begin failures++; $display("FAIL rmid_fs_valid got=%0h exp=0", fs_valid); end
    checks++; if (fs_inst_unable !== 1'b1) begin failures++; $display("FAIL rmid_unable got=%0h exp=1", fs_inst_unable); end
    checks++; if (fs_to_ds_valid !== 1'b0) begin failures++; $display("FAIL rmid_ds_valid got=%0h exp=0", fs_to_ds_valid); end
    checks++; if (fs_allowin !== 1'b1) begin failures++; $display("FAIL rmid_allowin got=%0h exp=1", fs_allowin); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_bypass();
    test_buffer();
    test_cancel();
    test_flush_claim();
    test_misaligned();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter EXC_ADEL, default 5'h04, excode reported for misaligned fetch PC.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pfs_to_fs_valid  input  1  pre-fetch stage offers a fetch.
REQ-005 SHALL have port pfs_to_fs_bus  input  65  {inst_ok[64], inst[63:32], pc[31:0]}.
REQ-006 SHALL have port pfs_inst_waiting  input  1  pre-fetch stage has an accepted address with no returned data.
REQ-007 SHALL have port fs_allowin  output  1  stage can accept a fetch this cycle.
REQ-008 SHALL have port fs_valid  output  1  stage holds a live instruction; used for branch delay-slot tracking.
REQ-009 SHALL have port fs_inst_unable  output  1  high when this stage does not claim the current inst_sram_data_ok.
REQ-010 SHALL have port inst_sram_rdata  input  32  instruction return data.
REQ-011 SHALL have port inst_sram_data_ok  input  1  one in-order data return per accepted address.
REQ-012 SHALL have port ds_allowin  input  1  decode stage accepts.
REQ-013 SHALL have port fs_to_ds_valid  output  1  instruction offered to decode.
REQ-014 SHALL have port fs_to_ds_bus  output  70  {ex[69], excode[68:64], inst[63:32], pc[31:0]}.
REQ-015 SHALL have ports ws_ex, ws_eret  input  1 each  writeback flush requests.

Function
REQ-016 SHALL accept a fetch when pfs_to_fs_valid && fs_allowin, latching pc and, if inst_ok, inst into a buffer marked full.
REQ-017 SHALL define waiting = fs_valid && !buf_full; while waiting, inst_sram_data_ok with cancel_cnt==0 is claimed by this stage.
REQ-018 SHALL define fs_ready_go = buf_full || (waiting && inst_sram_data_ok && cancel_cnt==0).
REQ-019 SHALL drive fs_allowin = !fs_valid || (fs_ready_go && ds_allowin).
REQ-020 SHALL drive fs_to_ds_valid = fs_valid && fs_ready_go && !ws_ex && !ws_eret.
REQ-021 SHALL forward inst from buffer when full, else inst_sram_rdata directly (zero-latency bypass).
REQ-022 SHALL store a claimed data word into the buffer when ds_allowin is low, holding it until handoff.
REQ-023 SHALL drive fs_inst_unable = !waiting && cancel_cnt==0.
REQ-024 SHALL keep a 2-bit cancel_cnt of in-flight returns to discard; max value 2, never wraps.
REQ-025 SHALL on ws_ex||ws_eret add (waiting && !(inst_sram_data_ok && cancel_cnt==0)) + pfs_inst_waiting to cancel_cnt.
REQ-026 SHALL decrement cancel_cnt by 1 on each inst_sram_data_ok while cancel_cnt!=0; data discarded, not buffered.
REQ-027 SHALL apply increment and decrement of the same cycle together (net change).
REQ-028 SHALL on ws_ex||ws_eret clear fs_valid and buf_full next cycle, unless a new fetch is accepted that cycle (upstream suppresses it).
REQ-029 SHALL on fs_allowin with no accepted fetch clear fs_valid.
REQ-030 SHALL set ex=1, excode=EXC_ADEL, inst=32'h0 when pc[1:0]!=0; data return still consumed normally; else ex=0, excode=0.

Reset
REQ-031 SHALL on reset clear fs_valid, buf_full, cancel_cnt, buffered inst and pc to 0; fs_allowin=1, fs_to_ds_valid=0, fs_inst_unable=1 the cycle after reset.
REQ-032 SHALL ignore inst_sram_data_ok during reset.

Verification
REQ-033 Fetch pc=bfc00000 inst_ok=0, data_ok+rdata=24020001 next cycle, ds_allowin=1 -> fs_to_ds_valid same cycle, bus inst=24020001, pc=bfc00000.
REQ-034 Data returns with ds_allowin=0 for 3 cycles -> buffer holds 24020001, fs_allowin=0, handoff on ds_allowin rise, then fs_allowin=1.
REQ-035 ws_ex while waiting and pfs_inst_waiting=1 -> cancel_cnt=2, next two data_ok discarded, fs_inst_unable=0 until cancel_cnt=0.
REQ-036 ws_eret same cycle as claimed data_ok, pfs_inst_waiting=0 -> cancel_cnt stays 0, fs_to_ds_valid=0, fs_valid=0 next cycle.
REQ-037 Fetch pc=bfc00002 -> ex=1, excode=04, inst=0, pc=bfc00002 after data_ok.
REQ-038 Reset asserted with cancel_cnt=1 and buffer full -> all state cleared next cycle, fs_inst_unable=1.
